// File: rtl/counter_pwm.sv
// counter_pwm
//   Consumes a free-running WIDTH-bit count and produces a registered PWM
//   output by comparing each count against the active duty value. New duty
//   values arrive over a valid/ready handshake, are staged in a shadow
//   register and only become active at the period boundary (count all-ones),
//   so a period is never cut short or stretched mid-way. A sticky flag
//   reports any count step that is not +1 (a step to 0 is always accepted).
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   count        in   [WIDTH] counter value, expected to advance by 1 per clk
//   duty_data    in   [WIDTH] new duty value
//   duty_valid   in   duty_data is valid
//   duty_ready   out  shadow register free (no duty pending)
//   pwm          out  registered PWM output (XORed with INVERT)
//   wrap         out  one-cycle pulse after the count=all-ones edge
//   duty_active  out  [WIDTH] duty value used by the compare
//   seq_err      out  sticky sequence error flag
//   err_clr      in   synchronous clear of seq_err (a new error wins)
module counter_pwm #(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm,
  output logic             wrap,
  output logic [WIDTH-1:0] duty_active,
  output logic             seq_err,
  input  logic             err_clr
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_duty_active;
  logic             r_pending;
  logic             r_pwm;
  logic             r_wrap;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
  logic             r_seq_err;

  logic             w_all_ones;
  logic             w_xfer;
  logic [WIDTH-1:0] w_prev_inc;
  logic             w_seq_bad;

  assign w_all_ones = (count == {WIDTH{1'b1}});
  assign w_xfer     = duty_valid && !r_pending;
  // +1 wraps naturally at WIDTH bits, so all-ones -> 0 is a legal step.
  assign w_prev_inc = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
  // A step to 0 is always legal so an upstream counter reset resyncs quietly.
  assign w_seq_bad  = r_prev_valid && (count != w_prev_inc) && (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow      <= '0;
      r_duty_active <= '0;
      r_pending     <= 1'b0;
      r_pwm         <= INVERT;
      r_wrap        <= 1'b0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_wrap       <= w_all_ones;
      // Compare uses the duty value from before this edge's update, so a
      // newly applied duty starts exactly at count=0 of the next period.
      r_pwm        <= INVERT ^ (count < r_duty_active);
      r_prev       <= count;
      r_prev_valid <= 1'b1;

      // Apply requires pending=1 and a transfer requires pending=0, so the
      // two never collide; a transfer on the wrap edge waits a full period.
      if (w_all_ones && r_pending) begin
        r_duty_active <= r_shadow;
        r_pending     <= 1'b0;
      end
      if (w_xfer) begin
        r_shadow  <= duty_data;
        r_pending <= 1'b1;
      end

      if (w_seq_bad)    r_seq_err <= 1'b1;
      else if (err_clr) r_seq_err <= 1'b0;
    end
  end

  assign duty_ready  = !r_pending;
  assign pwm         = r_pwm;
  assign wrap        = r_wrap;
  assign duty_active = r_duty_active;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_counter_pwm.sv
// Directed bench for counter_pwm: two instances (INVERT=0 and INVERT=1)
// share one stimulus stream; the bench drives count itself.
module tb_counter_pwm;

  logic       clk;
  logic       reset_n;
  logic [7:0] count;
  logic [7:0] duty_data;
  logic       duty_valid;
  logic       err_clr;

  logic       ready0, pwm0, wrap0, seq0;
  logic [7:0] act0;
  logic       ready1, pwm1, wrap1, seq1;
  logic [7:0] act1;

  int checks = 0;
  int errors = 0;

  counter_pwm #(.WIDTH(8), .INVERT(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .count(count), .duty_data(duty_data),
    .duty_valid(duty_valid), .duty_ready(ready0), .pwm(pwm0), .wrap(wrap0),
    .duty_active(act0), .seq_err(seq0), .err_clr(err_clr)
  );

  counter_pwm #(.WIDTH(8), .INVERT(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .count(count), .duty_data(duty_data),
    .duty_valid(duty_valid), .duty_ready(ready1), .pwm(pwm1), .wrap(wrap1),
    .duty_active(act1), .seq_err(seq1), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    count = count + 8'd1;
  endtask

  task automatic run_to(input logic [7:0] v);
    while (count != v) step();
  endtask

  // One full period starting with count=0 about to be sampled. Any duty_valid
  // is dropped after the first edge so at most one transfer happens.
  task automatic period(output int h0, output int h1, output int nw,
                        output int l0, output int l1);
    h0 = 0; h1 = 0; nw = 0; l0 = 0; l1 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 0) duty_valid = 1'b0;
      h0 += int'(pwm0);
      h1 += int'(pwm1);
      nw += int'(wrap0);
      l0 = int'(pwm0);
      l1 = int'(pwm1);
    end
  endtask

  int h0, h1, nw, l0, l1;

  initial begin
    reset_n    = 1'b0;
    count      = 8'd0;
    duty_data  = 8'd0;
    duty_valid = 1'b0;
    err_clr    = 1'b0;

    // Reset while count runs, with a duty offered that must be ignored
    duty_valid = 1'b1;
    duty_data  = 8'd99;
    repeat (5) step();
    chk("rst_pwm0",   pwm0,   0);
    chk("rst_pwm1",   pwm1,   1);
    chk("rst_wrap",   wrap0,  0);
    chk("rst_ready",  ready0, 1);
    chk("rst_active", act0,   0);
    chk("rst_seqerr", seq0,   0);
    duty_valid = 1'b0;
    reset_n    = 1'b1;
    count      = 8'd0;

    // Duty load of 64 presented at count=10
    run_to(8'd10);
    duty_valid = 1'b1;
    duty_data  = 8'd64;
    step();
    duty_valid = 1'b0;
    chk("load_ready_drop", ready0, 0);
    run_to(8'd255);
    chk("load_pre_wrap_active", act0, 0);
    chk("load_pre_wrap_wrap", wrap0, 0);
    step();
    chk("load_wrap", wrap0, 1);
    chk("load_active", act0, 64);
    chk("load_ready_rise", ready0, 1);
    period(h0, h1, nw, l0, l1);
    chk("duty64_high0", h0, 64);
    chk("duty64_high1", h1, 192);
    chk("duty64_wraps", nw, 1);

    // Back-to-back: 200 then 30 with valid held
    duty_valid = 1'b1;
    duty_data  = 8'd200;
    step();
    chk("b2b_ready0", ready0, 0);
    duty_data = 8'd30;
    run_to(8'd255);
    chk("b2b_hold_ready", ready0, 0);
    chk("b2b_hold_active", act0, 64);
    step();
    chk("b2b_apply200", act0, 200);
    chk("b2b_ready_rise", ready0, 1);
    step();
    duty_valid = 1'b0;
    chk("b2b_accept30", ready0, 0);
    chk("b2b_still200", act0, 200);
    run_to(8'd255);
    step();
    chk("b2b_apply30", act0, 30);

    // Transfer of 128 on the very wrap edge (pending=0): not bypassed
    run_to(8'd255);
    duty_valid = 1'b1;
    duty_data  = 8'd128;
    step();
    duty_valid = 1'b0;
    chk("same_edge_wrap", wrap0, 1);
    chk("same_edge_active", act0, 30);
    chk("same_edge_ready", ready0, 0);
    period(h0, h1, nw, l0, l1);
    chk("duty30_high0", h0, 30);
    chk("duty30_high1", h1, 226);
    chk("same_edge_applied", act0, 128);

    // Extremes: load 0, then 255
    duty_valid = 1'b1;
    duty_data  = 8'd0;
    period(h0, h1, nw, l0, l1);
    chk("duty128_high0", h0, 128);
    chk("duty128_high1", h1, 128);
    chk("zero_applied", act0, 0);
    duty_valid = 1'b1;
    duty_data  = 8'd255;
    period(h0, h1, nw, l0, l1);
    chk("duty0_high0", h0, 0);
    chk("duty0_high1", h1, 256);
    chk("full_applied", act1, 255);
    period(h0, h1, nw, l0, l1);
    chk("duty255_high0", h0, 255);
    chk("duty255_high1", h1, 1);
    chk("duty255_last0", l0, 0);
    chk("duty255_last1", l1, 1);

    // Sequence checking
    chk("seq_clean", seq0, 0);
    run_to(8'd40);
    tick();
    count = 8'd45;
    tick();
    chk("seq_jump", seq0, 1);
    chk("seq_no_pwm_effect", act0, 255);
    count   = 8'd46;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("seq_clear", seq0, 0);
    count = 8'd0;
    tick();
    chk("seq_zero_legal", seq0, 0);
    count = 8'd1;
    tick();
    chk("seq_after_zero", seq0, 0);
    count   = 8'd9;
    err_clr = 1'b1;
    tick();
    chk("seq_set_wins", seq0, 1);
    err_clr = 1'b0;
    count   = 8'd10;
    tick();
    chk("seq_sticky", seq1, 1);
    err_clr = 1'b1;
    count   = 8'd11;
    tick();
    err_clr = 1'b0;
    chk("seq_clear2", seq0, 0);

    // Reset mid-period discards a pending duty
    count      = 8'd12;
    duty_valid = 1'b1;
    duty_data  = 8'd77;
    step();
    duty_valid = 1'b0;
    chk("midrst_pending", ready0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", ready0, 1);
    chk("midrst_active", act0, 0);
    chk("midrst_pwm1", pwm1, 1);
    reset_n = 1'b1;
    run_to(8'd255);
    step();
    chk("midrst_discard", act0, 0);
    chk("midrst_wrap", wrap0, 1);
    chk("midrst_seqerr", seq0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
